// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - Program run sequencer: resets, launches and times one core run.
module run_ctrl #(
    parameter int CW      = 16,
    parameter int TIMEOUT = 4096,
    parameter int RST_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_req,
    output logic          busy,
    output logic          res_valid,
    output logic [1:0]    status,
    output logic [CW-1:0] cycles,
    output logic [7:0]    run_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_REQ,
        S_RUN,
        S_DONE
    } state_t;

    localparam int             RCW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);
    localparam logic [CW-1:0]  TO_VAL   = CW'(TIMEOUT);

    localparam logic [1:0] ST_OK      = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORTED = 2'b11;

    state_t         state;
    state_t         state_next;
    logic [RCW-1:0] rst_cnt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;
    logic           run_tmo;
    logic           run_end;

    // cnt_inc is the count including the cycle being sampled now; it saturates at TIMEOUT.
    always_comb begin
        cnt_inc = (cnt == TO_VAL) ? cnt : cnt + CW'(1);
        run_tmo = (cnt_inc == TO_VAL);
        run_end = core_done | abort | run_tmo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RESET;
            S_RESET: if (rst_cnt == RST_LAST) state_next = S_REQ;
            S_REQ:   state_next = S_RUN;
            S_RUN:   if (run_end) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        core_reset = (state == S_IDLE) || (state == S_RESET);
        core_req   = (state == S_REQ);
        busy       = (state != S_IDLE);
        res_valid  = (state == S_DONE);
    end

    // Results are written on the edge that enters DONE so they are visible during DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_cnt <= '0;
            cnt     <= '0;
            status  <= 2'b00;
            cycles  <= '0;
            run_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rst_cnt <= '0;
                end
                S_RESET: begin
                    rst_cnt <= (rst_cnt == RST_LAST) ? '0 : rst_cnt + RCW'(1);
                end
                S_REQ: begin
                    cnt <= '0;
                end
                S_RUN: begin
                    cnt <= cnt_inc;
                    if (run_end) begin
                        cycles  <= cnt_inc;
                        run_cnt <= run_cnt + 8'd1;
                        if (core_done) begin
                            status <= ST_OK;
                        end else if (abort) begin
                            status <= ST_ABORTED;
                        end else begin
                            status <= ST_TIMEOUT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - Self-checking bench for run_ctrl with vector table and random runs.
module tb_run_ctrl;

    localparam int TO = 8;
    localparam int RC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        core_done;
    logic        core_reset;
    logic        core_req;
    logic        busy;
    logic        res_valid;
    logic [1:0]  status;
    logic [15:0] cycles;
    logic [7:0]  run_cnt;

    int total = 0;
    int bad   = 0;
    int exp_rc = 0;

    run_ctrl #(.CW(16), .TIMEOUT(TO), .RST_CYC(RC)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .core_done(core_done),
        .core_reset(core_reset), .core_req(core_req), .busy(busy), .res_valid(res_valid),
        .status(status), .cycles(cycles), .run_cnt(run_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         d;
        int         a;
        bit         noise;
        logic [1:0] st;
        int         cy;
    } vec_t;

    typedef struct {
        int          n_rst;
        int          n_req;
        int          n_valid;
        logic [1:0]  st;
        logic [15:0] cy;
        logic [7:0]  rc;
        bit          stable;
        bit          idle_after;
        bit          tmo;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First event in time wins; on a tie done beats abort beats timeout.
    task automatic model(input int d, input int a, output logic [1:0] st, output int cy);
        cy = TO;
        st = 2'b10;
        if (a >= 1 && a <= cy) begin cy = a; st = 2'b11; end
        if (d >= 1 && d <= cy) begin cy = d; st = 2'b01; end
    endtask

    // Event d/a is asserted only in that RUN cycle (1-based); 0 means never.
    task automatic run_once(input int d, input int a, input bit noise, output res_t r);
        logic [1:0]  st0;
        logic [15:0] cy0;
        logic [7:0]  rc0;
        int k = 0;
        bit fin = 0;
        r = '{default: 0};
        r.stable = 1;
        st0 = status; cy0 = cycles; rc0 = run_cnt;
        start = 1'b1;
        step();
        for (int t = 0; t < 200 && !fin; t++) begin
            start = 1'b0; core_done = 1'b0; abort = 1'b0;
            if (res_valid) begin
                r.n_valid++;
                r.st = status; r.cy = cycles; r.rc = run_cnt;
                fin = 1;
            end else begin
                if (status !== st0 || cycles !== cy0 || run_cnt !== rc0) r.stable = 0;
                if (core_reset && busy) begin
                    r.n_rst++;
                    if (noise) core_done = 1'b1;
                end else if (core_req) begin
                    r.n_req++;
                end else if (busy) begin
                    k++;
                    core_done = (k == d);
                    abort     = (k == a);
                    if (noise && (k == 1 || k == 2)) start = 1'b1;
                end
            end
            step();
        end
        start = 1'b0; core_done = 1'b0; abort = 1'b0;
        r.tmo = !fin;
        r.idle_after = !busy && !res_valid;
    endtask

    task automatic check_run(input string tag, input res_t r, input logic [1:0] st, input int cy);
        exp_rc = (exp_rc + 1) & 255;
        check({tag, " timeout_wait"}, r.tmo, 0);
        check({tag, " reset_cycles"}, r.n_rst, RC);
        check({tag, " req_pulses"}, r.n_req, 1);
        check({tag, " valid_pulses"}, r.n_valid, 1);
        check({tag, " status"}, r.st, st);
        check({tag, " cycles"}, r.cy, cy);
        check({tag, " run_cnt"}, r.rc, exp_rc);
        check({tag, " held_stable"}, r.stable, 1);
        check({tag, " idle_after"}, r.idle_after, 1);
    endtask

    vec_t tbl[10];

    initial begin
        res_t r;
        logic [1:0] mst;
        int mcy;
        int k;

        tbl[0] = '{5, 0, 0, 2'b01, 5};
        tbl[1] = '{0, 0, 0, 2'b10, 8};
        tbl[2] = '{3, 3, 0, 2'b01, 3};
        tbl[3] = '{0, 3, 0, 2'b11, 3};
        tbl[4] = '{1, 0, 1, 2'b01, 1};
        tbl[5] = '{0, 1, 0, 2'b11, 1};
        tbl[6] = '{8, 0, 0, 2'b01, 8};
        tbl[7] = '{0, 8, 1, 2'b11, 8};
        tbl[8] = '{9, 9, 0, 2'b10, 8};
        tbl[9] = '{4, 2, 1, 2'b11, 2};

        reset = 1'b0; start = 1'b0; abort = 1'b0; core_done = 1'b0;
        #1;
        check("rst core_reset", core_reset, 1);
        check("rst core_req", core_req, 0);
        check("rst busy", busy, 0);
        check("rst res_valid", res_valid, 0);
        check("rst status", status, 0);
        check("rst cycles", cycles, 0);
        check("rst run_cnt", run_cnt, 0);
        step();
        step();
        reset = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_once(tbl[i].d, tbl[i].a, tbl[i].noise, r);
            check_run($sformatf("vec%0d", i), r, tbl[i].st, tbl[i].cy);
        end

        for (int i = 0; i < 40; i++) begin
            int d, a;
            bit n;
            d = $urandom_range(0, 10);
            a = $urandom_range(0, 10);
            n = 1'($urandom_range(0, 1));
            model(d, a, mst, mcy);
            run_once(d, a, n, r);
            check_run($sformatf("rnd%0d d=%0d a=%0d", i, d, a), r, mst, mcy);
        end

        // Reset asserted in RUN cycle 4 abandons the run.
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        for (int t = 0; t < 50 && k < 4; t++) begin
            if (busy && !core_reset && !core_req && !res_valid) k++;
            if (k < 4) step();
        end
        check("mid reached_run4", k, 4);
        reset = 1'b0;
        #1;
        check("mid core_reset", core_reset, 1);
        check("mid core_req", core_req, 0);
        check("mid busy", busy, 0);
        check("mid res_valid", res_valid, 0);
        check("mid status", status, 0);
        check("mid cycles", cycles, 0);
        check("mid run_cnt", run_cnt, 0);
        step();
        check("mid held res_valid", res_valid, 0);
        check("mid held busy", busy, 0);
        reset = 1'b1;
        exp_rc = 0;
        run_once(2, 0, 0, r);
        check_run("post_reset", r, 2'b01, 2);

        reset = 1'b0;
        #2;
        reset = 1'b1;
        exp_rc = 0;
        step();
        for (int i = 0; i < 256; i++) begin
            run_once(1, 0, 0, r);
            exp_rc = (exp_rc + 1) & 255;
            if (i % 32 == 31) check($sformatf("wrap run_cnt i=%0d", i), r.rc, exp_rc);
        end
        check("wrap final run_cnt", r.rc, 0);
        check("wrap final status", r.st, 2'b01);
        check("wrap final valid", r.n_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter CW, default 16: width of the run cycle counter.
REQ-002 SHALL have parameter TIMEOUT, default 4096: maximum RUN cycles allowed before timeout (legal range 1..2^CW-1).
REQ-003 SHALL have parameter RST_CYC, default 2: number of cycles core_reset is held in the RESET state (legal range at least 1).
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: host request to launch one program run; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1: host request to stop the run in progress; sampled only in RUN.
REQ-008 SHALL have port core_done, input, 1: done level from the downstream core (PC reached end address).
REQ-009 SHALL have port core_reset, output, 1: active-high reset driven to the downstream core.
REQ-010 SHALL have port core_req, output, 1: one-cycle start pulse driven to the core's req input.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port res_valid, output, 1: one-cycle pulse marking that status and cycles have been updated.
REQ-013 SHALL have port status, output, 2: 00 = none, 01 = ok, 10 = timeout, 11 = aborted.
REQ-014 SHALL have port cycles, output, CW: RUN-cycle count of the last completed run.
REQ-015 SHALL have port run_cnt, output, 8: count of completed runs, wrapping from 255 to 0.

Function
REQ-016 SHALL implement the states IDLE, RESET, REQ, RUN and DONE.
REQ-017 SHALL move IDLE -> RESET on start=1; start SHALL be ignored in all other states.
REQ-018 SHALL hold RESET for exactly RST_CYC cycles with core_reset=1, then move to REQ; core_done SHALL be ignored in RESET.
REQ-019 SHALL drive core_reset=0 and core_req=1 for exactly one cycle in REQ, clear the internal counter to 0, then move to RUN.
REQ-020 SHALL increment the counter by 1 in every RUN cycle; the reported count includes the cycle in which the terminating event is sampled.
REQ-021 SHALL end RUN with status ok when core_done=1 is sampled, capturing cycles = the counter value including that cycle.
REQ-022 SHALL otherwise end RUN with status aborted when abort=1 is sampled.
REQ-023 SHALL otherwise end RUN with status timeout when the TIMEOUT-th RUN cycle passes without done or abort, capturing cycles = TIMEOUT.
REQ-024 SHALL resolve simultaneous events in one cycle with priority core_done > abort > timeout.
REQ-025 SHALL spend exactly one cycle in DONE, in which res_valid=1, status and cycles take their new values, and run_cnt increments; the next state is IDLE.
REQ-026 SHALL hold status, cycles and run_cnt stable outside the DONE update, including through the RESET, REQ and RUN states of the next run.
REQ-027 SHALL drive core_reset=1 in IDLE and RESET, and core_reset=0 in REQ, RUN and DONE.
REQ-028 SHALL drive core_req=1 only in REQ.
REQ-029 SHALL, while in RUN, keep the counter from wrapping; it stops at TIMEOUT.

Reset
REQ-030 SHALL, while reset=0 (asynchronously), force state=IDLE, core_reset=1, core_req=0, busy=0, res_valid=0, status=00, cycles=0, run_cnt=0 and counter=0.
REQ-031 SHALL, when reset is asserted mid-run, abandon the run without producing res_valid, and SHALL resume from IDLE on the first clock edge after reset returns to 1.

Verification
REQ-032 SHALL be verified for a normal run: RST_CYC=2, start pulse, core_done rises in the 5th RUN cycle -> core_reset high 2 cycles, a single core_req pulse, res_valid with status=01, cycles=5, run_cnt=1.
REQ-033 SHALL be verified for timeout: TIMEOUT=8, core_done held 0 -> res_valid after 8 RUN cycles, status=10, cycles=8.
REQ-034 SHALL be verified for simultaneous events: abort and core_done both high in RUN cycle 3 -> status=01, cycles=3; abort alone in cycle 3 -> status=11, cycles=3.
REQ-035 SHALL be verified for ignored stimulus: start pulses during RUN, and core_done high during RESET -> no extra run, no early completion, run_cnt advances by exactly 1.
REQ-036 SHALL be verified for reset mid-run: reset=0 in RUN cycle 4 -> outputs at reset values immediately with no res_valid; a subsequent run completes normally with run_cnt=1.
REQ-037 SHALL be verified for wrap-around: 256 back-to-back ok runs -> run_cnt=0, and the last res_valid reports status=01.
